// File: rtl/playfield_arbiter.sv
// ---------------------------------------------------------------------------
// playfield_arbiter
//
// Responder side of the piece-movement handshake. Holds the settled board
// (ROWS x COLS cells of 3-bit colour, 0 = empty), validates each proposed
// four-block position against bounds and occupied cells, and answers with
// one of:
//   movement_commit   - 1-cycle pulse, position accepted
//   movement_declined - level, position rejected (held until request drops)
//   movement_steal    - level, piece locked into the board (held likewise)
// A blocked natural fall writes the last committed position into the board
// and then sweeps rows bottom-up, collapsing every full row.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   movement_request            level request from the piece controller
//   movement_intent             0 = natural fall, 1 = player move/rotate
//   P1blk_v..P4blk_v            proposed lateral coordinates
//   P1blk_h..P4blk_h            proposed fall coordinates
//   volatile_blk_color          colour of the active piece
//   movement_commit/_declined/_steal   replies (mutually exclusive)
//   rd_row, rd_col, rd_color    renderer read port (0 when out of range)
//   lines_cleared               rows cleared since reset, wraps at 256
//   game_over                   sticky, a freshly spawned piece could not fall
//
// Configuration
//   PLAYFIELD_RDREG_EN  defined: rd_color registered (1-cycle latency)
//                       undefined: rd_color combinational
// ---------------------------------------------------------------------------
module playfield_arbiter #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       movement_request,
    input  logic       movement_intent,
    input  logic [4:0] P1blk_v,
    input  logic [4:0] P2blk_v,
    input  logic [4:0] P3blk_v,
    input  logic [4:0] P4blk_v,
    input  logic [4:0] P1blk_h,
    input  logic [4:0] P2blk_h,
    input  logic [4:0] P3blk_h,
    input  logic [4:0] P4blk_h,
    input  logic [2:0] volatile_blk_color,
    output logic       movement_commit,
    output logic       movement_declined,
    output logic       movement_steal,
    input  logic [4:0] rd_row,
    input  logic [4:0] rd_col,
    output logic [2:0] rd_color,
    output logic [7:0] lines_cleared,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DECIDE,
        S_LOCK,
        S_CLEAR,
        S_WAITLOW
    } state_t;

    typedef logic [2:0] color_t;

    localparam logic [4:0] ROWS_L   = 5'(ROWS);
    localparam logic [4:0] COLS_L   = 5'(COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    state_t     state, state_next;
    color_t     board      [ROWS][COLS];
    color_t     board_next [ROWS][COLS];

    logic [4:0] snap_v [4];
    logic [4:0] snap_h [4];
    logic [4:0] lc_v   [4];
    logic [4:0] lc_h   [4];
    logic       snap_intent;
    color_t     snap_color;
    logic [1:0] idx;
    logic       hit;
    logic       has_committed;
    logic [4:0] clr_row;

    logic [4:0] cur_v, cur_h, lock_v, lock_h;
    color_t     check_cell, rd_cell;
    logic       blocked, row_full;
    logic       do_commit, do_lock, do_gameover;

    // Block under test while checking, and cell being written while locking.
    assign cur_v  = snap_v[idx];
    assign cur_h  = snap_h[idx];
    assign lock_v = lc_v[idx];
    assign lock_h = lc_h[idx];

    // Board lookups by address compare; an address outside the board matches
    // nothing and therefore reads as empty.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        check_cell = '0;
        rd_cell    = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (cur_h == 5'(r) && cur_v == 5'(c)) check_cell = board[r][c];
                if (rd_row == 5'(r) && rd_col == 5'(c)) rd_cell = board[r][c];
            end
        end
    end

    always_comb begin
        row_full = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (clr_row == 5'(r)) begin
                row_full = 1'b1;
                for (int c = 0; c < COLS; c++) begin
                    if (board[r][c] == '0) row_full = 1'b0;
                end
            end
        end
    end

    // Negative coordinates arrive wrapped (e.g. 31) and fail the range test.
    assign blocked = (cur_v >= COLS_L) || (cur_h >= ROWS_L) || (check_cell != '0);

    // Reply decision once all four blocks have been examined.
    assign do_commit   = (state == S_DECIDE) && !game_over && !hit;
    assign do_lock     = (state == S_DECIDE) && !game_over && hit && !snap_intent && has_committed;
    assign do_gameover = (state == S_DECIDE) && !game_over && hit && !snap_intent && !has_committed;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (movement_request) state_next = S_CHECK;
            S_CHECK:   if (idx == 2'd3) state_next = S_DECIDE;
            S_DECIDE:  state_next = do_lock ? S_LOCK : S_WAITLOW;
            S_LOCK:    if (idx == 2'd3) state_next = S_CLEAR;
            S_CLEAR:   if (!row_full && clr_row == '0) state_next = S_WAITLOW;
            S_WAITLOW: if (!movement_request) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Board update: one locked cell per LOCK cycle; in CLEAR a full row r is
    // removed by pulling rows 0..r-1 down one place and emptying row 0.
    always_comb begin
        board_next = board;
        if (state == S_LOCK) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (lock_h == 5'(r) && lock_v == 5'(c)) board_next[r][c] = snap_color;
                end
            end
        end else if (state == S_CLEAR && row_full) begin
            for (int r = ROWS - 1; r > 0; r--) begin
                if (5'(r) <= clr_row) board_next[r] = board[r - 1];
            end
            for (int c = 0; c < COLS; c++) board_next[0][c] = '0;
        end
    end

    // NOTE: the board array is reset explicitly; a reset mid-lock or mid-clear
    // must leave an empty field, so it cannot be treated as uninitialised RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) board[r][c] <= '0;
            end
        end else begin
            board <= board_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                snap_v[i] <= '0;
                snap_h[i] <= '0;
                lc_v[i]   <= '0;
                lc_h[i]   <= '0;
            end
            snap_intent       <= 1'b0;
            snap_color        <= '0;
            idx               <= '0;
            hit               <= 1'b0;
            has_committed     <= 1'b0;
            clr_row           <= '0;
            movement_commit   <= 1'b0;
            movement_declined <= 1'b0;
            movement_steal    <= 1'b0;
            lines_cleared     <= '0;
            game_over         <= 1'b0;
        end else begin
            movement_commit <= do_commit;
            case (state)
                S_IDLE: begin
                    if (movement_request) begin
                        snap_v[0]   <= P1blk_v;
                        snap_v[1]   <= P2blk_v;
                        snap_v[2]   <= P3blk_v;
                        snap_v[3]   <= P4blk_v;
                        snap_h[0]   <= P1blk_h;
                        snap_h[1]   <= P2blk_h;
                        snap_h[2]   <= P3blk_h;
                        snap_h[3]   <= P4blk_h;
                        snap_intent <= movement_intent;
                        snap_color  <= volatile_blk_color;
                        idx         <= '0;
                        hit         <= 1'b0;
                    end
                end
                S_CHECK: begin
                    hit <= hit | blocked;
                    idx <= idx + 2'd1;   // wraps to 0, ready for LOCK
                end
                S_DECIDE: begin
                    if (do_commit) begin
                        lc_v          <= snap_v;
                        lc_h          <= snap_h;
                        has_committed <= 1'b1;
                    end
                    if (do_gameover) game_over <= 1'b1;
                    if (!do_commit && !do_lock) movement_declined <= 1'b1;
                end
                S_LOCK: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) clr_row <= LAST_ROW;
                end
                S_CLEAR: begin
                    // A collapsed row brings new content into r, so r is re-tested.
                    if (row_full) begin
                        lines_cleared <= lines_cleared + 8'd1;
                    end else if (clr_row == '0) begin
                        movement_steal <= 1'b1;
                        has_committed  <= 1'b0;
                    end else begin
                        clr_row <= clr_row - 5'd1;
                    end
                end
                S_WAITLOW: begin
                    if (!movement_request) begin
                        movement_declined <= 1'b0;
                        movement_steal    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PLAYFIELD_RDREG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_color <= '0;
        else        rd_color <= rd_cell;
    end
`else
    assign rd_color = rd_cell;
`endif

endmodule
